// File: rtl/prog_mod_counter_pkg.sv
// prog_mod_counter_pkg
//   Shared types and helpers for the programmable-modulus counter.
//   dir_e     : count direction encoding (matches the up_dn port value).
//   MIN_MOD   : smallest legal modulus.
//   mod_legal : true when a modulus lies in MIN_MOD..2^width.
package prog_mod_counter_pkg;

   typedef enum logic {
      DIR_DN = 1'b0,
      DIR_UP = 1'b1
   } dir_e;

   localparam int unsigned MIN_MOD = 2;

   function automatic logic mod_legal(input int unsigned val, input int unsigned width);
      return (val >= MIN_MOD) && (val <= (32'd1 << width));
   endfunction

endpackage

// File: rtl/prog_mod_counter_mod_cfg_reg.sv
// mod_cfg_reg
//   Owns the modulus register M, the legality check on writes and the
//   sticky cfg_err flag.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     mod_wr    : modulus write strobe
//     mod_val   : requested modulus (WIDTH+1 bits)
//     modulus   : registered modulus M
//     mod_eff   : M as it will be after this edge (write value when legal)
//     mod_upd   : a legal write is being accepted this cycle
//     cfg_err   : set by any illegal write, cleared only by rst
module mod_cfg_reg
   import prog_mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned DEFAULT_MOD = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mod_wr,
   input  logic [WIDTH:0]   mod_val,
   output logic [WIDTH:0]   modulus,
   output logic [WIDTH:0]   mod_eff,
   output logic             mod_upd,
   output logic             cfg_err
);

   localparam logic [WIDTH:0] RST_MOD = (WIDTH+1)'(DEFAULT_MOD);

   if (!mod_legal(DEFAULT_MOD, WIDTH)) begin : g_bad_default
      $error("prog_mod_counter: DEFAULT_MOD outside 2..2^WIDTH");
   end

   assign mod_upd = mod_wr & mod_legal(32'(mod_val), WIDTH);
   assign mod_eff = mod_upd ? mod_val : modulus;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         modulus <= RST_MOD;
         cfg_err <= 1'b0;
      end else begin
         if (mod_upd) begin
            modulus <= mod_val;
         end
         if (mod_wr && !mod_upd) begin
            cfg_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/prog_mod_counter.sv
// prog_mod_counter
//   Up/down counter with a run-time programmable modulus M (2..2^WIDTH),
//   wrap or saturate behaviour at the terminal values, synchronous load
//   and a one-cycle wrap pulse.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     en        : count enable
//     up_dn     : 1 = up, 0 = down
//     sat_mode  : 1 = saturate at terminal value, 0 = wrap
//     load      : load strobe, load_val clamped to M-1
//     load_val  : value to load
//     mod_wr    : modulus write strobe
//     mod_val   : new modulus
//     count     : current count (always < M)
//     modulus   : effective modulus M
//     tc        : combinational terminal-count flag
//     wrap      : registered pulse, one cycle after a wrap
//     cfg_err   : sticky illegal-modulus flag
module prog_mod_counter
   import prog_mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned DEFAULT_MOD = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mod_wr,
   input  logic [WIDTH:0]   mod_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH:0]   modulus,
   output logic             tc,
   output logic             wrap,
   output logic             cfg_err
);

   logic [WIDTH:0]   mod_eff;
   logic             mod_upd;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] term_eff;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] count_nxt;
   logic             wrap_nxt;
   dir_e             dir;

   mod_cfg_reg #(
      .WIDTH       (WIDTH),
      .DEFAULT_MOD (DEFAULT_MOD)
   ) u_cfg (
      .clk     (clk),
      .rst     (rst),
      .mod_wr  (mod_wr),
      .mod_val (mod_val),
      .modulus (modulus),
      .mod_eff (mod_eff),
      .mod_upd (mod_upd),
      .cfg_err (cfg_err)
   );

   // M-1 always fits in WIDTH bits because M <= 2^WIDTH.
   assign term     = WIDTH'(modulus - (WIDTH+1)'(1));
   assign term_eff = WIDTH'(mod_eff - (WIDTH+1)'(1));

   // Load clamps against the modulus that will be in force after this edge.
   assign load_clamped = ({1'b0, load_val} < mod_eff) ? load_val : term_eff;

   assign dir = dir_e'(up_dn);

   assign tc = en & (((dir == DIR_UP) & (count == term)) |
                     ((dir == DIR_DN) & (count == '0)));

   always_comb begin
      count_nxt = count;
      wrap_nxt  = 1'b0;
      if (mod_wr) begin
         // A modulus write cycle never counts; it only loads or
         // pulls an out-of-range count back to zero.
         if (load) begin
            count_nxt = load_clamped;
         end else if (mod_upd && ({1'b0, count} >= mod_eff)) begin
            count_nxt = '0;
         end
      end else if (load) begin
         count_nxt = load_clamped;
      end else if (en) begin
         case (dir)
            DIR_UP: begin
               if (count < term) begin
                  count_nxt = count + WIDTH'(1);
               end else if (!sat_mode) begin
                  count_nxt = '0;
                  wrap_nxt  = 1'b1;
               end else begin
                  count_nxt = term;
               end
            end
            DIR_DN: begin
               if (count != '0) begin
                  count_nxt = count - WIDTH'(1);
               end else if (!sat_mode) begin
                  count_nxt = term;
                  wrap_nxt  = 1'b1;
               end
            end
            default: begin
               count_nxt = count;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         count <= count_nxt;
         wrap  <= wrap_nxt;
      end
   end

endmodule
